// File: rtl/fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_port_arbiter
//
// Shares one fifo buffer between NREQ write requesters and one read consumer,
// and adds a flush (drain) sequence. All buffer commands are registered. A
// shadow occupancy count is updated when a command is issued, one edge before
// the buffer executes it. The buffer therefore never overflows or underflows,
// and no command is lost.
//
// Parameters
//   NREQ        number of write requesters (2..8)
//   DATA_WIDTH  data word width, equal to the buffer's width
//   DEPTH       buffer depth, equal to the buffer's depth
//
// Ports
//   clk         clock
//   reset       synchronous, active-high; the buffer is reset on the same edge
//   req         per-requester write request (level)
//   req_data    requester i drives bits [i*DATA_WIDTH +: DATA_WIDTH]
//   ack         one-hot pulse: the word of requester i was accepted
//   rd_req      consumer read request (level)
//   rd_ack      pulse: a read was issued to the buffer
//   flush       pulse: start draining the buffer
//   flush_done  one-cycle pulse when the drain completes
//   busy        high while a flush is in progress
//   occ         shadow occupancy (issued writes minus issued reads)
//   buf_write   to the buffer's write pin
//   buf_datain  to the buffer's datain; holds the last accepted word
//   buf_read    to the buffer's read pin
// -----------------------------------------------------------------------------
module fifo_port_arbiter #(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   localparam int OCC_W     = $clog2(DEPTH) + 1,
   localparam int PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data,
   output logic [NREQ-1:0]            ack,
   input  logic                       rd_req,
   output logic                       rd_ack,
   input  logic                       flush,
   output logic                       flush_done,
   output logic                       busy,
   output logic [OCC_W-1:0]           occ,
   output logic                       buf_write,
   output logic [DATA_WIDTH-1:0]      buf_datain,
   output logic                       buf_read
);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t                  state, state_nxt;
   logic [PTR_W-1:0]        ptr, ptr_nxt;
   logic [NREQ-1:0]         ack_nxt;
   logic                    rd_ack_nxt;
   logic                    buf_write_nxt;
   logic                    buf_read_nxt;
   logic [DATA_WIDTH-1:0]   buf_datain_nxt;
   logic [OCC_W-1:0]        occ_nxt;
   logic                    flush_done_nxt;

   // Round-robin search
   logic [NREQ-1:0]         elig;
   logic                    any_elig;
   logic [PTR_W-1:0]        grant_idx;
   logic [PTR_W-1:0]        grant_next_ptr;

   // A requester whose ack is high this cycle has not yet seen it and may
   // still hold req. Masking it here prevents one word being taken twice.
   always_comb begin
      elig      = req & ~ack;
      any_elig  = |elig;
      grant_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         // Walking downward means the lowest offset from ptr is written last
         // and wins. The result is a first-match search starting at ptr.
         if (elig[(int'(ptr) + k) % NREQ]) begin
            grant_idx = PTR_W'((int'(ptr) + k) % NREQ);
         end
      end
      grant_next_ptr = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PTR_W'(1);
   end

   // Next-state and next-output logic.
   // NOTE: every variable gets a default first; a path that skips an
   // assignment would otherwise infer a latch.
   always_comb begin
      logic rd_ok;
      logic wr_ok;

      state_nxt      = state;
      ptr_nxt        = ptr;
      ack_nxt        = '0;
      rd_ack_nxt     = 1'b0;
      buf_write_nxt  = 1'b0;
      buf_read_nxt   = 1'b0;
      buf_datain_nxt = buf_datain;
      occ_nxt        = occ;
      flush_done_nxt = 1'b0;

      // The buffer ignores a simultaneous read+write when empty. For that
      // reason a read is never issued at occ==0. At full, a read that is
      // issued alongside a write keeps the write legal.
      rd_ok = rd_req && (occ != '0);
      wr_ok = any_elig && ((occ < OCC_W'(DEPTH)) || rd_ok);

      unique case (state)
         IDLE: begin
            if (flush) begin
               state_nxt = FLUSH;
            end else begin
               if (wr_ok) begin
                  ack_nxt[grant_idx] = 1'b1;
                  buf_write_nxt      = 1'b1;
                  buf_datain_nxt     = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                  ptr_nxt            = grant_next_ptr;
               end
               if (rd_ok) begin
                  rd_ack_nxt   = 1'b1;
                  buf_read_nxt = 1'b1;
               end
               if (wr_ok && !rd_ok) begin
                  occ_nxt = occ + OCC_W'(1);
               end else if (rd_ok && !wr_ok) begin
                  occ_nxt = occ - OCC_W'(1);
               end
            end
         end

         FLUSH: begin
            // The consumer is not told about drain reads. Requests wait.
            if (occ != '0) begin
               buf_read_nxt = 1'b1;
               occ_nxt      = occ - OCC_W'(1);
            end else begin
               flush_done_nxt = 1'b1;
               state_nxt      = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only. Then every
   // register samples values from before the edge, whatever order they appear in.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         ack        <= '0;
         rd_ack     <= 1'b0;
         buf_write  <= 1'b0;
         buf_read   <= 1'b0;
         buf_datain <= '0;
         occ        <= '0;
         flush_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         ack        <= ack_nxt;
         rd_ack     <= rd_ack_nxt;
         buf_write  <= buf_write_nxt;
         buf_read   <= buf_read_nxt;
         buf_datain <= buf_datain_nxt;
         occ        <= occ_nxt;
         flush_done <= flush_done_nxt;
      end
   end

   assign busy = (state == FLUSH);

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_port_arbiter
//
// Directed bench for fifo_port_arbiter using the default parameters
// (NREQ=4, DATA_WIDTH=8, DEPTH=16). Each step drives inputs, advances one
// clock and then compares every output with its expected value. A queue
// receives the expected buf_datain word whenever a grant is expected. The word
// is popped and compared when buf_write is seen.
// -----------------------------------------------------------------------------
module tb_fifo_port_arbiter;

   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      ack;
   logic                 rd_req;
   logic                 rd_ack;
   logic                 flush;
   logic                 flush_done;
   logic                 busy;
   logic [OCC_W-1:0]     occ;
   logic                 buf_write;
   logic [DW-1:0]        buf_datain;
   logic                 buf_read;

   int                   checks = 0;
   int                   errors = 0;
   logic [DW-1:0]        sb[$];

   fifo_port_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .rd_req     (rd_req),
      .rd_ack     (rd_ack),
      .flush      (flush),
      .flush_done (flush_done),
      .busy       (busy),
      .occ        (occ),
      .buf_write  (buf_write),
      .buf_datain (buf_datain),
      .buf_read   (buf_read)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word(int i);
      return DW'(8'h11 * (i + 1));
   endfunction

   task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One clock step. Outputs are sampled 1 time unit after the edge.
   task automatic tick();
      logic [DW-1:0] exp_word;
      @(posedge clk);
      #1;
      if (buf_write === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_write", 32'(sb.size()), 32'd1);
         end else begin
            exp_word = sb.pop_front();
            check("sb_datain", 32'(buf_datain), 32'(exp_word));
         end
      end
   endtask

   task automatic cyc(string tag, logic [NREQ-1:0] e_ack, logic e_rd_ack,
                      logic e_wr, logic e_rd, logic [OCC_W-1:0] e_occ,
                      logic e_fd, logic e_busy);
      check({tag, ".ack"},        32'(ack),        32'(e_ack));
      check({tag, ".rd_ack"},     32'(rd_ack),     32'(e_rd_ack));
      check({tag, ".buf_write"},  32'(buf_write),  32'(e_wr));
      check({tag, ".buf_read"},   32'(buf_read),   32'(e_rd));
      check({tag, ".occ"},        32'(occ),        32'(e_occ));
      check({tag, ".flush_done"}, 32'(flush_done), 32'(e_fd));
      check({tag, ".busy"},       32'(busy),       32'(e_busy));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seq1[5];
      int seq2[4];
      seq1 = '{2, 3, 0, 1, 2};
      seq2 = '{1, 2, 3, 0};

      reset  = 1'b1;
      req    = '1;
      rd_req = 1'b0;
      flush  = 1'b0;
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = word(i);

      // Reset held two cycles with every request high
      tick(); cyc("rst0", '0, 0, 0, 0, '0, 0, 0);
      check("rst0.datain", 32'(buf_datain), 32'd0);
      tick(); cyc("rst1", '0, 0, 0, 0, '0, 0, 0);
      reset = 1'b0;

      // Round-robin fill: 0,1,2,3,... one grant per cycle up to full
      for (int k = 0; k < DEPTH; k++) begin
         sb.push_back(word(k % NREQ));
         tick();
         cyc($sformatf("rr%0d", k), NREQ'(1 << (k % NREQ)), 0, 1, 0, OCC_W'(k + 1), 0, 0);
      end
      repeat (2) begin
         tick(); cyc("full_hold", '0, 0, 0, 0, OCC_W'(DEPTH), 0, 0);
      end

      // Full: a read and a write issued together
      req = 4'b0100; rd_req = 1'b1;
      sb.push_back(word(2));
      tick(); cyc("full_both", 4'b0100, 1, 1, 1, OCC_W'(DEPTH), 0, 0);
      rd_req = 1'b0;
      repeat (2) begin
         tick(); cyc("full_noread", '0, 0, 0, 0, OCC_W'(DEPTH), 0, 0);
      end

      // Drain through the consumer
      req = '0; rd_req = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         tick(); cyc($sformatf("drain%0d", k), '0, 1, 0, 1, OCC_W'(DEPTH - 1 - k), 0, 0);
      end

      // Empty: no read is issued
      repeat (3) begin
         tick(); cyc("empty_rd", '0, 0, 0, 0, '0, 0, 0);
      end
      req = 4'b0010;
      sb.push_back(word(1));
      tick(); cyc("empty_wr", 4'b0010, 0, 1, 0, OCC_W'(1), 0, 0);
      req = '0;
      tick(); cyc("empty_rd_after", '0, 1, 0, 1, '0, 0, 0);
      rd_req = 1'b0;
      tick(); cyc("idle", '0, 0, 0, 0, '0, 0, 0);

      // Fill to 5, then flush
      req = '1;
      for (int k = 0; k < 5; k++) begin
         sb.push_back(word(seq1[k]));
         tick();
         cyc($sformatf("fill%0d", k), NREQ'(1 << seq1[k]), 0, 1, 0, OCC_W'(k + 1), 0, 0);
      end
      req = 4'b0001; flush = 1'b1;
      tick(); cyc("flush_enter", '0, 0, 0, 0, OCC_W'(5), 0, 1);
      for (int k = 0; k < 5; k++) begin
         flush = (k == 1);   // a second pulse during FLUSH is ignored
         tick(); cyc($sformatf("flush_rd%0d", k), '0, 0, 0, 1, OCC_W'(4 - k), 0, 1);
      end
      flush = 1'b0;
      tick(); cyc("flush_done", '0, 0, 0, 0, '0, 1, 0);
      sb.push_back(word(0));
      tick(); cyc("flush_resume", 4'b0001, 0, 1, 0, OCC_W'(1), 0, 0);

      // Refill to 5, then reset after two flush reads
      req = '1;
      for (int k = 0; k < 4; k++) begin
         sb.push_back(word(seq2[k]));
         tick();
         cyc($sformatf("refill%0d", k), NREQ'(1 << seq2[k]), 0, 1, 0, OCC_W'(k + 2), 0, 0);
      end
      req = '0; flush = 1'b1;
      tick(); cyc("flush2_enter", '0, 0, 0, 0, OCC_W'(5), 0, 1);
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick(); cyc($sformatf("flush2_rd%0d", k), '0, 0, 0, 1, OCC_W'(4 - k), 0, 1);
      end
      reset = 1'b1;
      tick(); cyc("mid_rst", '0, 0, 0, 0, '0, 0, 0);
      check("mid_rst.datain", 32'(buf_datain), 32'd0);
      reset = 1'b0;
      repeat (2) begin
         tick(); cyc("post_rst", '0, 0, 0, 0, '0, 0, 0);
      end

      // Flush at occ=0: flush_done two cycles after the pulse
      flush = 1'b1;
      tick(); cyc("flush0_enter", '0, 0, 0, 0, '0, 0, 1);
      flush = 1'b0;
      tick(); cyc("flush0_done", '0, 0, 0, 0, '0, 1, 0);
      tick(); cyc("flush0_idle", '0, 0, 0, 0, '0, 0, 0);

      // Reset cleared the pointer: requester 0 is granted first
      req = '1;
      sb.push_back(word(0));
      tick(); cyc("rst_ptr_grant", 4'b0001, 0, 1, 0, OCC_W'(1), 0, 0);
      req = '0;
      tick(); cyc("final_idle", '0, 0, 0, 0, OCC_W'(1), 0, 0);

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
